parking_gate_arbiter: RTL and testbench

Shares the single lot barrier gate between the entry lane (request raised once its password controller reaches the accepted state) and the exit lane. Tracks lot occupancy against a fixed capacity, arbitrates simultaneous requests round-robin, and sequences the gate through open, pass and close phases with a pass timeout. It sits between the per-lane access FSMs and the gate actuator.

---
 rtl/parking_gate_arbiter.sv | 175 +++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes with occupancy tracking and round-robin arbitration.
// Optional statistics counters are enabled by defining PARKING_GATE_STATS_EN.
module parking_gate_arbiter #(
   parameter int  CAPACITY     = 8,
   parameter int  OPEN_CYCLES  = 4,
   parameter int  PASS_TIMEOUT = 16,
   parameter int  CLOSE_CYCLES = 4,
   localparam int CW           = $clog2(CAPACITY + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          entry_req,
   input  logic          exit_req,
   input  logic          pass_sensor,
   output logic          entry_gnt,
   output logic          exit_gnt,
   output logic          gate_open,
   output logic [CW-1:0] occupancy,
   output logic          full,
   output logic          empty,
   output logic          timeout_err
`ifdef PARKING_GATE_STATS_EN
   ,
   output logic [15:0]   entry_total,
   output logic [15:0]   exit_total,
   output logic [7:0]    timeout_total
`endif
);

   localparam int MAX_PHASE = (OPEN_CYCLES > PASS_TIMEOUT)
                              ? ((OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES)
                              : ((PASS_TIMEOUT > CLOSE_CYCLES) ? PASS_TIMEOUT : CLOSE_CYCLES);
   localparam int PW = $clog2(MAX_PHASE + 1);

   localparam logic [PW-1:0] OPEN_LAST  = PW'(OPEN_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST  = PW'(PASS_TIMEOUT - 1);
   localparam logic [PW-1:0] CLOSE_LAST = PW'(CLOSE_CYCLES - 1);
   localparam logic [CW-1:0] CAP        = CW'(CAPACITY);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OPENING = 2'd1,
      PASS    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] phase_cnt;
   logic          lane_entry;
   logic          last_entry;

   logic          entry_ok;
   logic          exit_ok;
   logic          grant_any;
   logic          grant_entry;
   logic          pass_done;
   logic          timed_out;

   logic          lane_entry_nxt;
   logic          last_entry_nxt;
   logic          entry_gnt_nxt;
   logic          exit_gnt_nxt;
   logic          gate_open_nxt;
   logic [CW-1:0] occupancy_nxt;
   logic          timeout_err_nxt;
`ifdef PARKING_GATE_STATS_EN
   logic [15:0]   entry_total_nxt;
   logic [15:0]   exit_total_nxt;
   logic [7:0]    timeout_total_nxt;
`endif

   assign entry_ok = entry_req & ~full;
   assign exit_ok  = exit_req & ~empty;

   // State and output registers; every output is driven from a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         lane_entry  <= 1'b0;
         last_entry  <= 1'b0;
         entry_gnt   <= 1'b0;
         exit_gnt    <= 1'b0;
         gate_open   <= 1'b0;
         occupancy   <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         timeout_err <= 1'b0;
`ifdef PARKING_GATE_STATS_EN
         entry_total   <= '0;
         exit_total    <= '0;
         timeout_total <= '0;
`endif
      end else begin
         state       <= state_nxt;
         phase_cnt   <= (state_nxt != state || state_nxt == IDLE) ? '0 : phase_cnt + 1'b1;
         lane_entry  <= lane_entry_nxt;
         last_entry  <= last_entry_nxt;
         entry_gnt   <= entry_gnt_nxt;
         exit_gnt    <= exit_gnt_nxt;
         gate_open   <= gate_open_nxt;
         occupancy   <= occupancy_nxt;
         full        <= (occupancy_nxt == CAP);
         empty       <= (occupancy_nxt == '0);
         timeout_err <= timeout_err_nxt;
`ifdef PARKING_GATE_STATS_EN
         entry_total   <= entry_total_nxt;
         exit_total    <= exit_total_nxt;
         timeout_total <= timeout_total_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_any   = 1'b0;
      grant_entry = 1'b0;
      pass_done   = 1'b0;
      timed_out   = 1'b0;
      case (state)
         IDLE: begin
            if (entry_ok | exit_ok) begin
               grant_any   = 1'b1;
               // On contention the lane that was not served last wins.
               grant_entry = entry_ok & ~(exit_ok & last_entry);
               state_nxt   = OPENING;
            end
         end
         OPENING: begin
            if (phase_cnt == OPEN_LAST) state_nxt = PASS;
         end
         PASS: begin
            if (pass_sensor) begin
               pass_done = 1'b1;
               state_nxt = CLOSING;
            end else if (phase_cnt == PASS_LAST) begin
               timed_out = 1'b1;
               state_nxt = CLOSING;
            end
         end
         CLOSING: begin
            if (phase_cnt == CLOSE_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lane_entry_nxt  = grant_any ? grant_entry : lane_entry;
      last_entry_nxt  = grant_any ? grant_entry : last_entry;
      entry_gnt_nxt   = (state_nxt != IDLE) & lane_entry_nxt;
      exit_gnt_nxt    = (state_nxt != IDLE) & ~lane_entry_nxt;
      gate_open_nxt   = (state_nxt == PASS);
      timeout_err_nxt = timed_out;
      occupancy_nxt   = occupancy;
      // Eligibility already prevents wrap; the bounds are re-checked here regardless.
      if (pass_done & lane_entry & (occupancy < CAP))
         occupancy_nxt = occupancy + 1'b1;
      else if (pass_done & ~lane_entry & (occupancy != '0))
         occupancy_nxt = occupancy - 1'b1;
`ifdef PARKING_GATE_STATS_EN
      entry_total_nxt   = entry_total;
      exit_total_nxt    = exit_total;
      timeout_total_nxt = timeout_total;
      if (pass_done & lane_entry & ~(&entry_total))
         entry_total_nxt = entry_total + 1'b1;
      if (pass_done & ~lane_entry & ~(&exit_total))
         exit_total_nxt = exit_total + 1'b1;
      if (timed_out & ~(&timeout_total))
         timeout_total_nxt = timeout_total + 1'b1;
`endif
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: timeline model of gate sessions checked every cycle,
// plus directed sessions with hand-computed grant order, latencies and occupancy.
module tb_parking_gate_arbiter;

   localparam int CAPACITY     = 8;
   localparam int OPEN_CYCLES  = 4;
   localparam int PASS_TIMEOUT = 16;
   localparam int CLOSE_CYCLES = 4;
   localparam int CW           = $clog2(CAPACITY + 1);

   logic          clk         = 1'b0;
   logic          reset_n     = 1'b0;
   logic          entry_req   = 1'b0;
   logic          exit_req    = 1'b0;
   logic          pass_sensor = 1'b0;
   logic          entry_gnt;
   logic          exit_gnt;
   logic          gate_open;
   logic [CW-1:0] occupancy;
   logic          full;
   logic          empty;
   logic          timeout_err;
`ifdef PARKING_GATE_STATS_EN
   logic [15:0]   entry_total;
   logic [15:0]   exit_total;
   logic [7:0]    timeout_total;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   parking_gate_arbiter #(
      .CAPACITY    (CAPACITY),
      .OPEN_CYCLES (OPEN_CYCLES),
      .PASS_TIMEOUT(PASS_TIMEOUT),
      .CLOSE_CYCLES(CLOSE_CYCLES)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .entry_req    (entry_req),
      .exit_req     (exit_req),
      .pass_sensor  (pass_sensor),
      .entry_gnt    (entry_gnt),
      .exit_gnt     (exit_gnt),
      .gate_open    (gate_open),
      .occupancy    (occupancy),
      .full         (full),
      .empty        (empty),
      .timeout_err  (timeout_err)
`ifdef PARKING_GATE_STATS_EN
      ,
      .entry_total  (entry_total),
      .exit_total   (exit_total),
      .timeout_total(timeout_total)
`endif
   );

   // Session model: each grant edge fixes when the pass window opens; the pass or
   // timeout edge fixes when the session ends.
   int edge_no    = 0;
   bit sess       = 1'b0;
   bit own_entry  = 1'b0;
   bit last_entry = 1'b0;
   int p_start    = 0;
   int done_edge  = -1;
   int to_edge    = -1;
   int m_occ      = 0;

   task automatic model_step();
      bit e_ok;
      bit x_ok;
      if (!reset_n) begin
         edge_no    = 0;
         sess       = 1'b0;
         own_entry  = 1'b0;
         last_entry = 1'b0;
         done_edge  = -1;
         to_edge    = -1;
         m_occ      = 0;
      end else begin
         edge_no++;
         if (sess) begin
            if (done_edge < 0 && edge_no > p_start && edge_no <= p_start + PASS_TIMEOUT) begin
               if (pass_sensor) begin
                  done_edge = edge_no;
                  if (own_entry && m_occ < CAPACITY) m_occ++;
                  if (!own_entry && m_occ > 0) m_occ--;
               end else if (edge_no == p_start + PASS_TIMEOUT) begin
                  done_edge = edge_no;
                  to_edge   = edge_no;
               end
            end
            if (done_edge >= 0 && edge_no == done_edge + CLOSE_CYCLES) sess = 1'b0;
         end else begin
            e_ok = entry_req && (m_occ < CAPACITY);
            x_ok = exit_req && (m_occ > 0);
            if (e_ok || x_ok) begin
               own_entry  = e_ok && !(x_ok && last_entry);
               last_entry = own_entry;
               sess       = 1'b1;
               p_start    = edge_no + OPEN_CYCLES;
               done_edge  = -1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      model_step();
   end

   initial forever begin
      logic [CW+5:0] act_v;
      logic [CW+5:0] exp_v;
      @(negedge clk);
      act_v = {entry_gnt, exit_gnt, gate_open, occupancy, full, empty, timeout_err};
      exp_v = {sess && own_entry, sess && !own_entry,
               sess && (edge_no >= p_start) && (done_edge < 0),
               CW'(m_occ), m_occ == CAPACITY, m_occ == 0,
               (to_edge >= 0) && (to_edge == edge_no)};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL cycle_outputs t=%0t: got {egnt,xgnt,open,occ,full,empty,to}=%b required %b",
                  $time, act_v, exp_v);
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One gate session: raise requests, drop the granted one, pulse the sensor in
   // PASS cycle pass_at (0 = never) and wait for the grant to fall.
   task automatic session(input bit e, input bit x, input int pass_at,
                          output int lane, output int open_lat,
                          output int close_lat, output int to_cnt);
      int t;
      lane      = -1;
      open_lat  = -1;
      close_lat = -1;
      to_cnt    = 0;
      entry_req = e;
      exit_req  = x;
      t = 0;
      while (!(entry_gnt || exit_gnt) && t < 12) begin
         @(negedge clk);
         t++;
      end
      if (!(entry_gnt || exit_gnt)) return;
      lane = entry_gnt ? 1 : 0;
      if (entry_gnt) entry_req = 1'b0;
      else exit_req = 1'b0;
      while (!gate_open && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!gate_open) return;
      open_lat = t;
      if (pass_at > 0) begin
         repeat (pass_at - 1) @(negedge clk);
         pass_sensor = 1'b1;
         @(negedge clk);
         pass_sensor = 1'b0;
      end
      t = 0;
      while ((entry_gnt || exit_gnt) && t < 40) begin
         if (timeout_err) to_cnt++;
         @(negedge clk);
         t++;
      end
      if (!(entry_gnt || exit_gnt)) close_lat = t;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int lane, ol, cl, to, seen, n;
      repeat (3) @(negedge clk);
      check("reset_empty", int'(empty), 1);
      check("reset_occupancy", int'(occupancy), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single entry, vehicle passes in the third PASS cycle.
      session(1'b1, 1'b0, 3, lane, ol, cl, to);
      check("t1_lane", lane, 1);
      check("t1_open_latency", ol, OPEN_CYCLES + 1);
      check("t1_close_latency", cl, CLOSE_CYCLES);
      check("t1_occupancy", int'(occupancy), 1);
      check("t1_empty", int'(empty), 0);

      for (int i = 0; i < 3; i++) session(1'b1, 1'b0, 2, lane, ol, cl, to);
      check("t2_prefill_occ", int'(occupancy), 4);
      session(1'b0, 1'b1, 1, lane, ol, cl, to);
      check("t2_prefill_exit_lane", lane, 0);
      check("t2_occ_before_contention", int'(occupancy), 3);

      // Both lanes requesting: expected order entry, exit, entry.
      session(1'b1, 1'b1, 2, lane, ol, cl, to);
      check("t2_first_lane", lane, 1);
      check("t2_occ_a", int'(occupancy), 4);
      session(1'b1, 1'b1, 2, lane, ol, cl, to);
      check("t2_second_lane", lane, 0);
      check("t2_occ_b", int'(occupancy), 3);
      session(1'b1, 1'b1, 2, lane, ol, cl, to);
      exit_req = 1'b0;
      check("t2_third_lane", lane, 1);
      check("t2_occ_c", int'(occupancy), 4);

      // Fill to capacity, then an entry request must be refused.
      for (int i = 0; i < 4; i++) session(1'b1, 1'b0, 5, lane, ol, cl, to);
      check("t3_full_occ", int'(occupancy), CAPACITY);
      check("t3_full_flag", int'(full), 1);
      entry_req = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (entry_gnt || exit_gnt || gate_open) seen++;
      end
      check("t3_full_blocks_entry", seen, 0);
      session(1'b1, 1'b1, 2, lane, ol, cl, to);
      check("t3_exit_served_lane", lane, 0);
      check("t3_occ_after_exit", int'(occupancy), CAPACITY - 1);
      session(1'b1, 1'b0, 2, lane, ol, cl, to);
      check("t3_entry_then_lane", lane, 1);
      check("t3_occ_refilled", int'(occupancy), CAPACITY);

      // Timeout, then a pass exactly on the timeout cycle.
      session(1'b0, 1'b1, 2, lane, ol, cl, to);
      session(1'b1, 1'b0, 0, lane, ol, cl, to);
      check("t4_timeout_lane", lane, 1);
      check("t4_timeout_pulses", to, 1);
      check("t4_occ_unchanged", int'(occupancy), CAPACITY - 1);
      session(1'b1, 1'b0, PASS_TIMEOUT, lane, ol, cl, to);
      check("t4_last_cycle_pulses", to, 0);
      check("t4_last_cycle_occ", int'(occupancy), CAPACITY);

      // Asynchronous reset while the gate is open.
      exit_req = 1'b1;
      n = 0;
      while (!exit_gnt && n < 12) begin
         @(negedge clk);
         n++;
      end
      exit_req = 1'b0;
      while (!gate_open && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t5_reached_pass", int'(gate_open), 1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_gate_open", int'(gate_open), 0);
      check("t5_rst_grants", int'({entry_gnt, exit_gnt}), 0);
      check("t5_rst_occupancy", int'(occupancy), 0);
      check("t5_rst_empty", int'(empty), 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Exit request with an empty lot is never granted; stray sensor ignored.
      exit_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         pass_sensor = (i == 3);
         @(negedge clk);
         if (exit_gnt || entry_gnt || gate_open) seen++;
      end
      pass_sensor = 1'b0;
      exit_req    = 1'b0;
      check("t5_empty_blocks_exit", seen, 0);

      // Fresh activity after reset: 2 entries, 1 exit, 1 timeout.
      session(1'b1, 1'b0, 2, lane, ol, cl, to);
      check("t6_entry1_occ", int'(occupancy), 1);
      session(1'b1, 1'b0, 4, lane, ol, cl, to);
      session(1'b0, 1'b1, 1, lane, ol, cl, to);
      check("t6_exit_occ", int'(occupancy), 1);
      session(1'b1, 1'b0, 0, lane, ol, cl, to);
      check("t6_timeout_pulses", to, 1);
      check("t6_final_occ", int'(occupancy), 1);
`ifdef PARKING_GATE_STATS_EN
      check("stats_entry_total", int'(entry_total), 2);
      check("stats_exit_total", int'(exit_total), 1);
      check("stats_timeout_total", int'(timeout_total), 1);
`endif
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
